// File: rtl/regression_pkg.sv
// Shared types and constants for the regression engine front end.
// Holds the loader state enum, default frame geometry and FP exponent field helpers.
package regression_pkg;

  localparam int unsigned NSamplesDef = 200;
  localparam int unsigned NFeatDef    = 10;

  localparam int unsigned ExpMsb     = 30;
  localparam int unsigned ExpLsb     = 23;
  localparam logic [7:0]  ExpAllOnes = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StKick,
    StWait
  } state_e;

  // True for any single-precision NaN or infinity (exponent all ones).
  function automatic logic is_nan_inf(input logic [31:0] word);
    return word[ExpMsb:ExpLsb] == ExpAllOnes;
  endfunction

endpackage

// File: rtl/sample_loader.sv
// Streams one frame of FP32 samples into the X/Y BRAMs, then hands off to the accumulator.
// Features go to both X copies, targets to Y; frame framing errors are flagged sticky.
module sample_loader
  import regression_pkg::*;
#(
  parameter int unsigned N_SAMPLES = NSamplesDef,
  parameter int unsigned N_FEAT    = NFeatDef,
  parameter int unsigned DW        = 32,
  parameter int unsigned XAW       = 11,
  parameter int unsigned YAW       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_go,
  input  logic           s_valid,
  input  logic [DW-1:0]  s_data,
  input  logic           s_last,
  output logic           s_ready,
  output logic           x_we,
  output logic [XAW-1:0] x_addr,
  output logic [DW-1:0]  x_din,
  output logic           y_we,
  output logic [YAW-1:0] y_addr,
  output logic [DW-1:0]  y_din,
  output logic           calc_start,
  input  logic           calc_done,
  output logic           busy,
  output logic           err_short,
  output logic           err_long,
  output logic [7:0]     nan_cnt
);

  localparam logic [3:0] FeatLast = 4'(N_FEAT);
  localparam logic [7:0] SampLast = 8'(N_SAMPLES - 1);

  state_e         state_q;
  logic [3:0]     feat_idx_q;
  logic [7:0]     samp_idx_q;
  logic [XAW-1:0] x_ptr_q;

  logic           x_we_q;
  logic [XAW-1:0] x_addr_q;
  logic [DW-1:0]  x_din_q;
  logic           y_we_q;
  logic [YAW-1:0] y_addr_q;
  logic [DW-1:0]  y_din_q;
  logic           calc_start_q;
  logic           err_short_q;
  logic           err_long_q;
  logic [7:0]     nan_cnt_q;

  logic beat;
  logic is_target;
  logic final_word;

  assign s_ready    = (state_q == StLoad) || (state_q == StFlush);
  assign beat       = s_valid && s_ready;
  assign is_target  = (feat_idx_q == FeatLast);
  assign final_word = is_target && (samp_idx_q == SampLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      feat_idx_q   <= '0;
      samp_idx_q   <= '0;
      x_ptr_q      <= '0;
      x_we_q       <= 1'b0;
      x_addr_q     <= '0;
      x_din_q      <= '0;
      y_we_q       <= 1'b0;
      y_addr_q     <= '0;
      y_din_q      <= '0;
      calc_start_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      nan_cnt_q    <= '0;
    end else begin
      x_we_q       <= 1'b0;
      y_we_q       <= 1'b0;
      calc_start_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          feat_idx_q <= '0;
          samp_idx_q <= '0;
          x_ptr_q    <= '0;
          if (load_go) begin
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            nan_cnt_q   <= '0;
            state_q     <= StLoad;
          end
        end

        StLoad: begin
          if (beat) begin
            if (!is_target) begin
              x_we_q     <= 1'b1;
              x_addr_q   <= x_ptr_q;
              x_din_q    <= s_data;
              x_ptr_q    <= x_ptr_q + XAW'(1);
              feat_idx_q <= feat_idx_q + 4'd1;
            end else begin
              y_we_q     <= 1'b1;
              y_addr_q   <= YAW'(samp_idx_q);
              y_din_q    <= s_data;
              feat_idx_q <= '0;
              samp_idx_q <= samp_idx_q + 8'd1;
            end

            if (final_word) begin
              if (s_last) begin
                state_q <= StKick;
              end else begin
                err_long_q <= 1'b1;
                state_q    <= StFlush;
              end
            end else if (s_last) begin
              err_short_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end

        StFlush: begin
          if (beat && s_last) begin
            state_q <= StIdle;
          end
        end

        // Entered one cycle after the final write, so the pulse trails the last BRAM write.
        StKick: begin
          calc_start_q <= 1'b1;
          state_q      <= StWait;
        end

        StWait: begin
          if (calc_done) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase

      if (beat && is_nan_inf(s_data[31:0]) && (nan_cnt_q != 8'hFF)) begin
        nan_cnt_q <= nan_cnt_q + 8'd1;
      end
    end
  end

  assign x_we       = x_we_q;
  assign x_addr     = x_addr_q;
  assign x_din      = x_din_q;
  assign y_we       = y_we_q;
  assign y_addr     = y_addr_q;
  assign y_din      = y_din_q;
  assign calc_start = calc_start_q;
  assign busy       = (state_q != StIdle);
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign nan_cnt    = nan_cnt_q;

endmodule

// File: tb/tb_sample_loader.sv
// Randomised self-checking bench for sample_loader: a frame-index reference model checked
// every cycle, plus literal expectations for frame geometry, errors, handoff and reset.
module tb_sample_loader;

  localparam int unsigned NS    = 200;
  localparam int unsigned NF    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned XAW   = 11;
  localparam int unsigned YAW   = 8;
  localparam int          FRAME = NS * (NF + 1);

  localparam int MIdle  = 0;
  localparam int MLoad  = 1;
  localparam int MFlush = 2;
  localparam int MKick  = 3;
  localparam int MWait  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           load_go;
  logic           s_valid;
  logic [DW-1:0]  s_data;
  logic           s_last;
  logic           s_ready;
  logic           x_we;
  logic [XAW-1:0] x_addr;
  logic [DW-1:0]  x_din;
  logic           y_we;
  logic [YAW-1:0] y_addr;
  logic [DW-1:0]  y_din;
  logic           calc_start;
  logic           calc_done;
  logic           busy;
  logic           err_short;
  logic           err_long;
  logic [7:0]     nan_cnt;

  sample_loader #(
    .N_SAMPLES(NS),
    .N_FEAT   (NF),
    .DW       (DW),
    .XAW      (XAW),
    .YAW      (YAW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_go   (load_go),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .x_we      (x_we),
    .x_addr    (x_addr),
    .x_din     (x_din),
    .y_we      (y_we),
    .y_addr    (y_addr),
    .y_din     (y_din),
    .calc_start(calc_start),
    .calc_done (calc_done),
    .busy      (busy),
    .err_short (err_short),
    .err_long  (err_long),
    .nan_cnt   (nan_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit abort  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f32(input int unsigned k);
    int unsigned p;
    logic [31:0] m;
    if (k == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (k[i]) p = i;
    m = (k << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Reference model: tracks the frame by word index k rather than by per-field counters.
  int          m_mode = MIdle;
  int          m_k    = 0;
  bit          m_es, m_el, m_xwe, m_ywe, m_cs;
  int          m_nan;
  int          m_xaddr, m_yaddr;
  logic [31:0] m_xdin, m_ydin;

  always @(posedge clk) begin
    m_xwe = 1'b0;
    m_ywe = 1'b0;
    m_cs  = 1'b0;
    if (reset) begin
      m_mode = MIdle; m_k = 0; m_es = 0; m_el = 0; m_nan = 0;
    end else begin
      case (m_mode)
        MIdle: if (load_go) begin
          m_es = 0; m_el = 0; m_nan = 0; m_k = 0; m_mode = MLoad;
        end
        MLoad: if (s_valid) begin
          if (s_data[30:23] == 8'hFF && m_nan < 255) m_nan++;
          if (m_k % (NF + 1) < NF) begin
            m_xwe = 1'b1;
            m_xaddr = (m_k / (NF + 1)) * NF + m_k % (NF + 1);
            m_xdin = s_data;
          end else begin
            m_ywe = 1'b1;
            m_yaddr = m_k / (NF + 1);
            m_ydin = s_data;
          end
          if (m_k == FRAME - 1) begin
            if (s_last) m_mode = MKick;
            else begin m_el = 1'b1; m_mode = MFlush; end
          end else if (s_last) begin
            m_es = 1'b1; m_mode = MIdle;
          end
          m_k++;
        end
        MFlush: if (s_valid) begin
          if (s_data[30:23] == 8'hFF && m_nan < 255) m_nan++;
          if (s_last) m_mode = MIdle;
        end
        MKick: begin m_cs = 1'b1; m_mode = MWait; end
        MWait: if (calc_done) m_mode = MIdle;
        default: m_mode = MIdle;
      endcase
    end
  end

  // Per-phase statistics gathered from the DUT outputs.
  int          xw_cnt, yw_cnt, both_cnt, cs_cnt, rdy_cnt, max_xaddr, max_yaddr, addr58;
  logic [63:0] wr_q[$];
  logic [63:0] ref_q[$];

  task automatic clear_stats();
    xw_cnt = 0; yw_cnt = 0; both_cnt = 0; cs_cnt = 0; rdy_cnt = 0;
    max_xaddr = -1; max_yaddr = -1; addr58 = -1;
    wr_q.delete();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_we", x_we, m_xwe);
      chk("y_we", y_we, m_ywe);
      if (m_xwe) begin
        chk("x_addr", x_addr, m_xaddr);
        chk("x_din", x_din, m_xdin);
      end
      if (m_ywe) begin
        chk("y_addr", y_addr, m_yaddr);
        chk("y_din", y_din, m_ydin);
      end
      chk("calc_start", calc_start, m_cs);
      chk("s_ready", s_ready, (m_mode == MLoad) || (m_mode == MFlush));
      chk("busy", busy, m_mode != MIdle);
      chk("err_short", err_short, m_es);
      chk("err_long", err_long, m_el);
      chk("nan_cnt", nan_cnt, m_nan);
    end
    if (x_we) begin
      xw_cnt++;
      if (int'(x_addr) > max_xaddr) max_xaddr = int'(x_addr);
      if (x_din == f32(58)) addr58 = int'(x_addr);
      wr_q.push_back({8'h00, 24'(x_addr), x_din});
    end
    if (y_we) begin
      yw_cnt++;
      if (int'(y_addr) > max_yaddr) max_yaddr = int'(y_addr);
      wr_q.push_back({8'h01, 24'(y_addr), y_din});
    end
    if (x_we && y_we) both_cnt++;
    if (calc_start) cs_cnt++;
    if (s_ready) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit bp,
                           output bit acc);
    int tries;
    acc = 1'b0;
    if (abort) return;
    if (bp) begin
      while ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tries   = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      if (!acc) begin
        tries++;
        if (tries > 50) begin
          n_cmp++;
          n_err++;
          $display("FAIL ready_timeout: s_ready stayed 0, expected 1 within 50 cycles");
          abort = 1'b1;
          break;
        end
      end
    end
    s_last = 1'b0;
  endtask

  task automatic end_stream();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_done();
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
  endtask

  bit acc;
  int beats;
  int mism;

  initial begin
    reset = 1'b1; load_go = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    calc_done = 1'b0;
    clear_stats();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_x_we", x_we, 0);
    chk("rst_calc_start", calc_start, 0);
    chk("rst_nan_cnt", nan_cnt, 0);
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Clean frame, s_valid held high.
    clear_stats();
    start_frame();
    for (int k = 0; k < FRAME; k++) send_word(f32(k), k == FRAME - 1, 1'b0, acc);
    end_stream();
    @(negedge clk);
    chk("cs_after_1", calc_start, 0);
    tick();
    @(negedge clk);
    chk("cs_after_2", calc_start, 1);
    repeat (4) tick();
    chk("clean_xw", xw_cnt, 2000);
    chk("clean_yw", yw_cnt, 200);
    chk("clean_max_xaddr", max_xaddr, 1999);
    chk("clean_max_yaddr", max_yaddr, 199);
    chk("clean_addr_s5f3", addr58, 53);
    chk("clean_cs_cnt", cs_cnt, 1);
    chk("clean_err_short", err_short, 0);
    chk("clean_err_long", err_long, 0);
    ref_q = wr_q;

    // Handoff: load_go held while waiting on the accumulator.
    rdy_cnt = 0;
    load_go = 1'b1;
    repeat (1000) tick();
    chk("wait_rdy_cnt", rdy_cnt, 0);
    chk("wait_busy", busy, 1);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    load_go   = 1'b0;
    @(negedge clk);
    chk("done_idle", busy, 0);
    repeat (3) tick();
    chk("idle_hold", busy, 0);
    chk("handoff_cs_cnt", cs_cnt, 1);

    // Random 50% backpressure must reproduce the clean write sequence.
    clear_stats();
    start_frame();
    for (int k = 0; k < FRAME; k++) send_word(f32(k), k == FRAME - 1, 1'b1, acc);
    end_stream();
    repeat (5) tick();
    chk("ref_len", ref_q.size(), FRAME);
    chk("bp_len", wr_q.size(), ref_q.size());
    mism = 0;
    if (wr_q.size() == ref_q.size())
      for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== ref_q[i]) mism++;
    chk("bp_seq_diff", mism, 0);
    chk("bp_both_we", both_cnt, 0);
    chk("bp_cs_cnt", cs_cnt, 1);
    pulse_done();
    tick();

    // Short frame: s_last on word 100.
    clear_stats();
    start_frame();
    for (int k = 0; k <= 100; k++) send_word(f32(k), k == 100, 1'b0, acc);
    end_stream();
    repeat (3) tick();
    chk("short_err", err_short, 1);
    chk("short_busy", busy, 0);
    chk("short_ready", s_ready, 0);
    chk("short_cs_cnt", cs_cnt, 0);
    chk("short_writes", xw_cnt + yw_cnt, 101);

    // Long frame: 2205 words, s_last on the last.
    clear_stats();
    start_frame();
    beats = 0;
    for (int k = 0; k < FRAME + 5; k++) begin
      send_word(f32(k), k == FRAME + 4, 1'b0, acc);
      if (acc) beats++;
    end
    end_stream();
    repeat (3) tick();
    chk("long_err", err_long, 1);
    chk("long_err_short_clr", err_short, 0);
    chk("long_busy", busy, 0);
    chk("long_writes", xw_cnt + yw_cnt, FRAME);
    chk("long_beats", beats, FRAME + 5);
    chk("long_cs_cnt", cs_cnt, 0);

    // NaN counting, then reset mid-frame at word 1500.
    clear_stats();
    start_frame();
    for (int k = 0; k < 1500; k++)
      send_word((k == 7 || k == 300 || k == 1234) ? 32'h7FC0_0000 : f32(k), 1'b0, 1'b0, acc);
    end_stream();
    @(negedge clk);
    chk("nan_cnt_3", nan_cnt, 3);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst2_busy", busy, 0);
    chk("rst2_nan", nan_cnt, 0);
    chk("rst2_x_addr", x_addr, 0);
    chk("rst2_x_din", x_din, 0);
    chk("rst2_y_addr", y_addr, 0);
    chk("rst2_s_ready", s_ready, 0);
    reset = 1'b0;
    tick();
    start_frame();
    send_word(f32(1), 1'b0, 1'b0, acc);
    end_stream();
    @(negedge clk);
    chk("restart_x_we", x_we, 1);
    chk("restart_x_addr", x_addr, 0);
    chk("restart_x_din", x_din, 32'h3F80_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sample_loader.md
Name: sample_loader

Overview:
- Upstream stage of the regression engine.
- Accepts a serial stream of IEEE-754 single-precision words, one frame = N_SAMPLES samples, each sample = N_FEAT feature words followed by one target word.
- Writes features to the X BRAM pair (same data to both copies) and targets to the Y BRAM.
- After a clean frame, pulses calc_start to kick the XtY/XtX accumulation stage, then holds off new frames until that stage reports calc_done.

Parameters:
- N_SAMPLES, 200, samples per frame.
- N_FEAT, 10, feature words per sample; the bias column is implicit and not stored.
- DW, 32, data word width.
- XAW, 11, X BRAM address width; must satisfy N_SAMPLES*N_FEAT <= 2**XAW.
- YAW, 8, Y BRAM address width; must satisfy N_SAMPLES <= 2**YAW.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- load_go  in  1  level; sampled only in IDLE, starts acceptance of one frame.
- s_valid  in  1  stream beat valid.
- s_data  in  DW  stream word.
- s_last  in  1  marks final word of frame.
- s_ready  out  1  loader accepts a beat this cycle.
- x_we  out  1  write enable, X1 and X2 BRAMs.
- x_addr  out  XAW  X write address.
- x_din  out  DW  X write data.
- y_we  out  1  write enable, Y BRAM.
- y_addr  out  YAW  Y write address.
- y_din  out  DW  Y write data.
- calc_start  out  1  one-cycle pulse to the accumulation stage.
- calc_done  in  1  strobe/level from the accumulation stage (its strb).
- busy  out  1  high in every state except IDLE.
- err_short  out  1  sticky; s_last arrived before the final word.
- err_long  out  1  sticky; final word arrived without s_last.
- nan_cnt  out  8  saturating count of accepted words with exponent 8'hFF.

Behaviour:
- Reset (synchronous, active-high): every output is 0 and the state is IDLE. Reset mid-frame or mid-WAIT aborts immediately; partially written BRAM contents are don't-care.
- Beat acceptance: a beat is accepted when s_valid && s_ready.
- s_ready = 1 only in LOAD and FLUSH. Combinational from state only; no dependency on s_valid.
- Counters:
  - feat_idx: 0..N_FEAT, 4 bits.
  - samp_idx: 0..N_SAMPLES-1, 8 bits.
  - x_ptr: running X address, incremented by 1 per feature word. No multiplier, so x_ptr always equals samp_idx*N_FEAT+feat_idx.
- Write latency is 1 cycle: an accepted beat produces the registered write on the next cycle.
  - feat_idx < N_FEAT: x_we=1, x_addr=x_ptr, x_din=s_data.
  - feat_idx == N_FEAT: y_we=1, y_addr=samp_idx, y_din=s_data.
  - x_we and y_we are never both high; both are 0 when no beat was accepted.
- After a target word: feat_idx wraps to 0 and samp_idx increments.
- nan_cnt increments on any accepted word with s_data[30:23]==8'hFF, saturating at 255. It is cleared on leaving IDLE for LOAD.
- State machine:
  - IDLE: counters are 0. If load_go: clear err_short, err_long and nan_cnt, then go to LOAD.
  - LOAD, on an accepted beat:
    - If it is the final word (samp_idx==N_SAMPLES-1 and feat_idx==N_FEAT):
      - with s_last: go to KICK;
      - without s_last: set err_long and go to FLUSH.
    - Else if s_last: set err_short and go to IDLE; no calc_start.
    - Else stay in LOAD.
    - No accepted beat: stay in LOAD with counters held.
  - FLUSH: accept and discard beats (no writes) until an accepted beat has s_last, then go to IDLE.
  - KICK: calc_start=1 for exactly this one cycle, then go to WAIT. It is entered one cycle after the final write, so the last write completes before calc_start.
  - WAIT: s_ready=0. BRAM ports belong to the accumulation stage. On calc_done go to IDLE. load_go is ignored here; in the same cycle as calc_done it has no effect.
- The final frame word is the last target word, frame index N_SAMPLES*(N_FEAT+1)-1 = 2199 at default parameters.
- Error flags are sticky until the next load_go accepted in IDLE, or reset.
- busy = (state != IDLE).

Decomposition:
- Package regression_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, KICK, WAIT);
  - N_SAMPLES and N_FEAT defaults;
  - the FP exponent field constants (bits 30:23, all-ones value).
- No sub-module: counters and the write register are in a single module.
- Optional helper function is_nan_inf(word) lives in the package.

Test Plan:
- Clean frame (default params), s_valid held high, word k = k as float:
  - 2000 X writes, addresses 0..1999; 200 Y writes, addresses 0..199; x_addr of sample 5 feature 3 = 53;
  - calc_start pulses exactly once, 2 cycles after the last beat;
  - err_short = err_long = 0.
- Backpressure: s_valid toggled randomly at 50% → write sequence identical to the clean-frame case; no write on idle cycles; x_we and y_we never simultaneously high.
- Short frame, s_last on word 100 → err_short=1, state IDLE, no calc_start, s_ready=0 afterwards.
- Long frame, 2205 words with s_last on the last → err_long=1; no writes after word 2199; FLUSH consumes 5 words, then IDLE; no calc_start.
- Handoff: hold calc_done=0 for 1000 cycles after KICK with load_go=1 → s_ready stays 0. Assert calc_done → IDLE next cycle; a new frame is accepted only via load_go in IDLE.
- NaN/reset: 3 words = 32'h7FC00000 → nan_cnt=3. Assert reset at word 1500 → all outputs 0 on the next edge; a fresh load_go restarts at x_addr=0.
